corner_detector: RTL

Automatic corner-detection stage launched by the top-level FSM's auto_detection_start pulse; returns auto_detection_done with four document corners.
- Raster-scans one thresholded luma frame from frame-buffer BRAM.
- Picks the four extreme "paper" pixels: TL = min(x+y), BR = max(x+y), TR = max(x−y), BL = min(x−y).
- Results seed manual corner adjustment and the parameter computation downstream.

---
 rtl/corner_detector.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/corner_detector.sv
// Raster-scans one thresholded luma frame from BRAM and reports the four extreme
// qualifying pixels: TL=min(x+y), BR=max(x+y), TR=max(x-y), BL=min(x-y).
module corner_detector #(
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 480,
    parameter int X_BITS      = 10,
    parameter int Y_BITS      = 9,
    parameter int ADDR_BITS   = 19,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           threshold,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [X_BITS-1:0]    tl_x,
    output logic [Y_BITS-1:0]    tl_y,
    output logic [X_BITS-1:0]    tr_x,
    output logic [Y_BITS-1:0]    tr_y,
    output logic [X_BITS-1:0]    bl_x,
    output logic [Y_BITS-1:0]    bl_y,
    output logic [X_BITS-1:0]    br_x,
    output logic [Y_BITS-1:0]    br_y
);

    localparam int SW = X_BITS + 1;
    localparam int DW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(H_PIXELS * V_PIXELS - 1);
    localparam logic [X_BITS-1:0]    X_LAST     = X_BITS'(H_PIXELS - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST     = Y_BITS'(V_PIXELS - 1);
    localparam logic [CW-1:0]        DRAIN_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [X_BITS-1:0]      x_q;
    logic [Y_BITS-1:0]      y_q;
    logic [CW-1:0]          drain_q;
    logic [7:0]             thr_q;

    logic                   vld_q [MEM_LATENCY];
    logic [X_BITS-1:0]      px_q  [MEM_LATENCY];
    logic [Y_BITS-1:0]      py_q  [MEM_LATENCY];

    logic                   wfound_q;
    logic [X_BITS-1:0]      w_tl_x_q, w_tr_x_q, w_bl_x_q, w_br_x_q;
    logic [Y_BITS-1:0]      w_tl_y_q, w_tr_y_q, w_bl_y_q, w_br_y_q;

    logic                   found_q;
    logic [X_BITS-1:0]      tl_x_q, tr_x_q, bl_x_q, br_x_q;
    logic [Y_BITS-1:0]      tl_y_q, tr_y_q, bl_y_q, br_y_q;

    logic                   hit;
    logic [X_BITS-1:0]      cx;
    logic [Y_BITS-1:0]      cy;
    logic [SW-1:0]          csum;
    logic signed [DW-1:0]   cdiff;

    function automatic logic [SW-1:0] f_sum(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
        return SW'(x) + SW'(y);
    endfunction

    function automatic logic signed [DW-1:0] f_diff(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
        return $signed(DW'(x)) - $signed(DW'(y));
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Address and (x,y) advance together so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= '0;
            thr_q   <= '0;
        end else begin
            drain_q <= (state_q == S_DRAIN) ? drain_q + CW'(1) : '0;
            if (state_q == S_IDLE && start) begin
                addr_q <= '0;
                x_q    <= '0;
                y_q    <= '0;
                thr_q  <= threshold;
            end else if (state_q == S_SCAN && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + ADDR_BITS'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_BITS'(1);
                end else begin
                    x_q <= x_q + X_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                px_q[i]  <= '0;
                py_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= (state_q == S_SCAN);
            px_q[0]  <= x_q;
            py_q[0]  <= y_q;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                px_q[i]  <= px_q[i-1];
                py_q[i]  <= py_q[i-1];
            end
        end
    end

    always_comb begin
        cx    = px_q[MEM_LATENCY-1];
        cy    = py_q[MEM_LATENCY-1];
        hit   = vld_q[MEM_LATENCY-1] && (mem_data >= thr_q);
        csum  = f_sum(cx, cy);
        cdiff = f_diff(cx, cy);
    end

    // Strict comparisons keep the earliest pixel in raster order on ties.
    always_ff @(posedge clk) begin
        if (!reset_n || (state_q == S_IDLE && start)) begin
            wfound_q <= 1'b0;
            w_tl_x_q <= '0; w_tl_y_q <= '0;
            w_tr_x_q <= '0; w_tr_y_q <= '0;
            w_bl_x_q <= '0; w_bl_y_q <= '0;
            w_br_x_q <= '0; w_br_y_q <= '0;
        end else if (hit) begin
            if (!wfound_q) begin
                wfound_q <= 1'b1;
                w_tl_x_q <= cx; w_tl_y_q <= cy;
                w_tr_x_q <= cx; w_tr_y_q <= cy;
                w_bl_x_q <= cx; w_bl_y_q <= cy;
                w_br_x_q <= cx; w_br_y_q <= cy;
            end else begin
                if (csum < f_sum(w_tl_x_q, w_tl_y_q)) begin
                    w_tl_x_q <= cx; w_tl_y_q <= cy;
                end
                if (csum > f_sum(w_br_x_q, w_br_y_q)) begin
                    w_br_x_q <= cx; w_br_y_q <= cy;
                end
                if (cdiff > f_diff(w_tr_x_q, w_tr_y_q)) begin
                    w_tr_x_q <= cx; w_tr_y_q <= cy;
                end
                if (cdiff < f_diff(w_bl_x_q, w_bl_y_q)) begin
                    w_bl_x_q <= cx; w_bl_y_q <= cy;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || (state_q == S_DONE && !wfound_q)) begin
            found_q <= 1'b0;
            tl_x_q  <= '0;     tl_y_q <= '0;
            tr_x_q  <= X_LAST; tr_y_q <= '0;
            bl_x_q  <= '0;     bl_y_q <= Y_LAST;
            br_x_q  <= X_LAST; br_y_q <= Y_LAST;
        end else if (state_q == S_DONE) begin
            found_q <= 1'b1;
            tl_x_q  <= w_tl_x_q; tl_y_q <= w_tl_y_q;
            tr_x_q  <= w_tr_x_q; tr_y_q <= w_tr_y_q;
            bl_x_q  <= w_bl_x_q; bl_y_q <= w_bl_y_q;
            br_x_q  <= w_br_x_q; br_y_q <= w_br_y_q;
        end
    end

    assign mem_addr = addr_q;
    assign found    = found_q;
    assign tl_x = tl_x_q;  assign tl_y = tl_y_q;
    assign tr_x = tr_x_q;  assign tr_y = tr_y_q;
    assign bl_x = bl_x_q;  assign bl_y = bl_y_q;
    assign br_x = br_x_q;  assign br_y = br_y_q;

endmodule
